// File: rtl/stopwatch_counter.sv
// BCD stopwatch MM:SS.mmm fed by a 1 ms tick, with a lap-hold display and clear.
// The live count always runs; the display shows either the live count or a held lap snapshot.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_tick,
    input  logic        clear,
    input  logic        lap,
    output logic [11:0] ms_bcd,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic        lap_active,
    output logic        rollover
);

    localparam logic [7:0] MIN_LIMIT_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Packed digit layout: [27:24] min tens .. [3:0] ms units
    logic [27:0] live_q, live_d;
    logic [27:0] hold_q, hold_d;
    logic [27:0] disp_q, disp_d;
    logic [27:0] nxt;
    state_e      state_q, state_d;
    logic        ms_tick_q, lap_q;
    logic        rollover_q, rollover_d;
    logic        inc, lap_rise, wrap;
    logic        c1, c2, c3, c4, c5, c6, c7;

    // Returns {carry_out, next_digit}; the >= test also pulls any stray non-BCD value back to 0.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic [3:0] max_digit,
                                            input logic       cin);
        if (!cin)
            return {1'b0, digit};
        else if (digit >= max_digit)
            return {1'b1, 4'd0};
        else
            return {1'b0, digit + 4'd1};
    endfunction

    assign inc      = ms_tick & ~ms_tick_q;
    assign lap_rise = lap & ~lap_q;

    always_comb begin
        nxt = '0;
        {c1, nxt[3:0]}   = bcd_step(live_q[3:0],   4'd9, inc);
        {c2, nxt[7:4]}   = bcd_step(live_q[7:4],   4'd9, c1);
        {c3, nxt[11:8]}  = bcd_step(live_q[11:8],  4'd9, c2);
        {c4, nxt[15:12]} = bcd_step(live_q[15:12], 4'd9, c3);
        {c5, nxt[19:16]} = bcd_step(live_q[19:16], 4'd5, c4);
        {c6, nxt[23:20]} = bcd_step(live_q[23:20], 4'd9, c5);
        {c7, nxt[27:24]} = bcd_step(live_q[27:24], 4'd9, c6);
        wrap = (c5 && (live_q[27:20] == MIN_LIMIT_BCD)) || c7;

        live_d     = nxt;
        rollover_d = 1'b0;
        if (clear) begin
            live_d = '0;
        end else if (wrap) begin
            live_d     = '0;
            rollover_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            LIVE: begin
                if (lap_rise) begin
                    hold_d  = live_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (lap_rise)
                    state_d = LIVE;
            end
            default: state_d = LIVE;
        endcase
        disp_d = (state_d == HOLD) ? hold_d : live_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LIVE;
            ms_tick_q  <= 1'b0;
            lap_q      <= 1'b0;
            live_q     <= '0;
            hold_q     <= '0;
            disp_q     <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_tick_q  <= ms_tick;
            lap_q      <= lap;
            live_q     <= live_d;
            hold_q     <= hold_d;
            disp_q     <= disp_d;
            rollover_q <= rollover_d;
        end
    end

    assign ms_bcd     = disp_q[11:0];
    assign sec_bcd    = disp_q[19:12];
    assign min_bcd    = disp_q[27:20];
    assign lap_active = (state_q == HOLD);
    assign rollover   = rollover_q;

endmodule
